// File: rtl/uart_io_unit_pkg.sv
// Shared types for the execute-stage UART I/O engine: run modes, FSM states, boot byte.
package io_pkg;

  typedef enum logic [2:0] {
    LOAD = 3'd1,
    EXEC = 3'd2
  } mode_t;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_IN_POP,
    IO_OUT_PUSH
  } io_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_FIRE,
    TX_WAIT
  } tx_state_t;

  localparam logic [7:0] BOOT_BYTE_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_io_unit_if.sv
// Execute-stage request/response bundle for IN/OUT instructions (start/busy/done handshake).
interface uart_io_unit_if;
  logic        start;
  logic        req_in;
  logic        req_out;
  logic [1:0]  req_bytes;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] rdata;
  logic        done;

  modport master (output start, req_in, req_out, req_bytes, wdata,
                  input  busy, rdata, done);
  modport slave  (input  start, req_in, req_out, req_bytes, wdata,
                  output busy, rdata, done);
endinterface

// File: rtl/uart_io_unit_fifo.sv
// io_byte_fifo: first-word-fall-through byte FIFO of 2**DEPTH_LOG2 entries with live count.
module io_byte_fifo #(
  parameter int unsigned DEPTH_LOG2 = 11
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                push,
  input  logic [7:0]          wdata,
  input  logic                pop,
  output logic [7:0]          rdata,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);
  localparam logic [DEPTH_LOG2:0]   DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  logic [7:0]            mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop && !empty;
  // A pop on a full FIFO frees the slot the simultaneous push writes into
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first; rx_ready pulses one cycle with the byte on rdata.
module uart_rx #(
  parameter int unsigned CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rx_ready
);
  localparam logic [15:0] HALF_END = 16'(CLK_PER_HALF_BIT - 1);
  localparam logic [15:0] BIT_END  = 16'(2 * CLK_PER_HALF_BIT - 1);

  logic        rx_s1, rx_s2, active;
  logic [15:0] cnt;
  logic [3:0]  bitn;
  logic [7:0]  sh;

  // bitn 0 = start bit (half-bit wait to centre), 1..8 = data, 9 = stop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      active   <= 1'b0;
      cnt      <= '0;
      bitn     <= '0;
      sh       <= '0;
      rdata    <= '0;
      rx_ready <= 1'b0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_ready <= 1'b0;
      if (!active) begin
        if (!rx_s2) begin
          active <= 1'b1;
          cnt    <= '0;
          bitn   <= '0;
        end
      end else if (cnt == ((bitn == 4'd0) ? HALF_END : BIT_END)) begin
        cnt <= '0;
        if (bitn == 4'd0) begin
          if (rx_s2) active <= 1'b0;
          else       bitn   <= 4'd1;
        end else if (bitn == 4'd9) begin
          active   <= 1'b0;
          rx_ready <= rx_s2;
          rdata    <= sh;
        end else begin
          sh   <= {rx_s2, sh[7:1]};
          bitn <= bitn + 4'd1;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first; tx_busy covers the whole frame including the stop bit.
module uart_tx #(
  parameter int unsigned CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_start,
  input  logic [7:0] sdata,
  output logic       tx_busy,
  output logic       txd
);
  localparam logic [15:0] BIT_END = 16'(2 * CLK_PER_HALF_BIT - 1);

  logic [9:0]  frame;
  logic [15:0] cnt;
  logic [3:0]  bitn;

  assign txd = tx_busy ? frame[0] : 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_busy <= 1'b0;
      frame   <= '1;
      cnt     <= '0;
      bitn    <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        frame   <= {1'b1, sdata, 1'b0};
        tx_busy <= 1'b1;
        cnt     <= '0;
        bitn    <= '0;
      end
    end else if (cnt == BIT_END) begin
      cnt <= '0;
      if (bitn == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        frame <= {1'b1, frame[9:1]};
        bitn  <= bitn + 4'd1;
      end
    end else begin
      cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: rtl/uart_io_unit.sv
// Buffered UART I/O engine: RX/TX FIFOs, 1-4 byte IN/OUT, LOAD-mode boot byte.
// UART_IO_STATS_EN adds rx_level/tx_level and a saturating rx_drop_cnt.
module uart_io_unit
  import io_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 434,
  parameter int unsigned RX_DEPTH_LOG2    = 11,
  parameter int unsigned TX_DEPTH_LOG2    = 11,
  parameter logic [7:0]  BOOT_BYTE        = BOOT_BYTE_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rxd,
  output logic            txd,
  input  mode_t           mode,
  uart_io_unit_if.slave   io,
  output logic            aa_received,
  output logic            aa_sent,
  output logic            rx_overflow
`ifdef UART_IO_STATS_EN
  ,
  output logic [RX_DEPTH_LOG2:0] rx_level,
  output logic [TX_DEPTH_LOG2:0] tx_level,
  output logic [15:0]            rx_drop_cnt
`endif
);
  logic [7:0]             rx_byte, rx_head, tx_head, tx_wbyte, odata;
  logic                   rx_valid, rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic                   tx_push, tx_pop, tx_full, tx_empty, tx_start, tx_busy;
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic [TX_DEPTH_LOG2:0] tx_count;

  uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rdata(rx_byte), .rx_ready(rx_valid));

  uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
    .clk(clk), .rstn(rstn), .tx_start(tx_start), .sdata(odata), .tx_busy(tx_busy), .txd(txd));

  io_byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_push), .wdata(rx_byte), .pop(rx_pop),
    .rdata(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty));

  io_byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(tx_push), .wdata(tx_wbyte), .pop(tx_pop),
    .rdata(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty));

  assign rx_push     = rx_valid && (mode == EXEC);
  assign rx_drop     = rx_push && rx_full && !rx_pop;
  assign aa_received = rx_valid && (rx_byte == BOOT_BYTE);

  // ---- IN/OUT request FSM ----
  io_state_t   io_state, io_state_d;
  logic [1:0]  n, k;
  logic [4:0]  lane_sh;
  logic [31:0] shreg, acc, rdata_q;
  logic        busy_reg, done_q, take, last;

  assign take     = io.start && (io.req_in || io.req_out);
  assign last     = (k == n);
  assign lane_sh  = {k, 3'b000};
  assign io.busy  = take || busy_reg;
  assign io.rdata = rdata_q;
  assign io.done  = done_q;
  assign tx_wbyte = shreg[7:0];

  always_comb begin
    io_state_d = io_state;
    rx_pop     = 1'b0;
    tx_push    = 1'b0;
    case (io_state)
      IO_IDLE: begin
        if (io.start && io.req_in)       io_state_d = IO_IN_POP;
        else if (io.start && io.req_out) io_state_d = IO_OUT_PUSH;
      end
      IO_IN_POP: begin
        rx_pop = !rx_empty;
        if (!rx_empty && last) io_state_d = IO_IDLE;
      end
      IO_OUT_PUSH: begin
        tx_push = !tx_full;
        if (!tx_full && last) io_state_d = IO_IDLE;
      end
      default: io_state_d = IO_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      io_state <= IO_IDLE;
      n        <= '0;
      k        <= '0;
      shreg    <= '0;
      acc      <= '0;
      rdata_q  <= '0;
      busy_reg <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      io_state <= io_state_d;
      done_q   <= 1'b0;
      if (io_state == IO_IDLE && take) begin
        n        <= io.req_bytes;
        k        <= '0;
        shreg    <= io.wdata;
        acc      <= '0;
        busy_reg <= 1'b1;
      end
      // The final lane bypasses acc so rdata updates on the same edge as done
      if (rx_pop) begin
        acc[lane_sh +: 8] <= rx_head;
        if (last) rdata_q <= acc | ({24'h0, rx_head} << lane_sh);
      end
      if (tx_push) shreg <= {8'h00, shreg[31:8]};
      if (rx_pop || tx_push) begin
        k <= k + 2'd1;
        if (last) begin
          done_q   <= 1'b1;
          busy_reg <= 1'b0;
        end
      end
    end
  end

  // ---- TX drain FSM ----
  tx_state_t tx_state, tx_state_d;
  logic      load_boot, boot_flight;

  always_comb begin
    tx_state_d = tx_state;
    tx_pop     = 1'b0;
    tx_start   = 1'b0;
    load_boot  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (mode == LOAD) begin
          if (!aa_sent) begin
            load_boot  = 1'b1;
            tx_state_d = TX_FIRE;
          end
        end else if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_FIRE;
        end
      end
      TX_FIRE: begin
        tx_start   = 1'b1;
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: if (!tx_busy) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state    <= TX_IDLE;
      odata       <= '0;
      boot_flight <= 1'b0;
      aa_sent     <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      if (load_boot) begin
        odata       <= BOOT_BYTE;
        boot_flight <= 1'b1;
      end else if (tx_pop) begin
        odata <= tx_head;
      end
      if (tx_state == TX_WAIT && !tx_busy && boot_flight) begin
        aa_sent     <= 1'b1;
        boot_flight <= 1'b0;
      end
      if (rx_drop) rx_overflow <= 1'b1;
    end
  end

`ifdef UART_IO_STATS_EN
  assign rx_level = rx_count;
  assign tx_level = tx_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                 rx_drop_cnt <= '0;
    else if (rx_drop && rx_drop_cnt != '1)     rx_drop_cnt <= rx_drop_cnt + 16'd1;
  end
`else
  logic stats_unused;
  assign stats_unused = ^{rx_count, tx_count};
`endif
endmodule

// File: tb/tb_uart_io_unit.sv
// Directed bench for uart_io_unit: boot byte, IN/OUT word assembly, stalls, overflow, reset.
module tb_uart_io_unit;
  import io_pkg::*;

  localparam int unsigned HB  = 4;
  localparam int unsigned BIT = 2 * HB;

  logic  clk = 1'b0;
  logic  rstn, rxd, txd, aa_received, aa_sent, rx_overflow;
  mode_t mode;

  uart_io_unit_if io();

  uart_io_unit #(
    .CLK_PER_HALF_BIT(HB),
    .RX_DEPTH_LOG2(2),
    .TX_DEPTH_LOG2(2),
    .BOOT_BYTE(8'hAA)
  ) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd), .mode(mode), .io(io),
    .aa_received(aa_received), .aa_sent(aa_sent), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Event counters sampled on the falling edge
  int   aa_rx_cnt = 0;
  int   done_cnt  = 0;
  logic done_prev = 1'b0;
  logic done_wide = 1'b0;
  always @(negedge clk) begin
    if (aa_received) aa_rx_cnt++;
    if (io.done) done_cnt++;
    if (io.done && done_prev) done_wide = 1'b1;
    done_prev = io.done;
  end

  // Decodes every frame seen on txd
  logic [7:0] tx_q[$];
  initial begin : tx_mon
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        repeat (HB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        tx_q.push_back(b);
      end
    end
  end

  function automatic logic [31:0] q_at(input int i);
    return (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic send_rx(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (BIT) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input logic is_in, input logic is_out, input logic [1:0] nb,
                       input logic [31:0] wd);
    @(negedge clk);
    io.start     = 1'b1;
    io.req_in    = is_in;
    io.req_out   = is_out;
    io.req_bytes = nb;
    io.wdata     = wd;
    #1 check("busy_on_start", 32'(io.busy), 1);
    @(negedge clk);
    io.start   = 1'b0;
    io.req_in  = 1'b0;
    io.req_out = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output int cycles);
    cycles = 0;
    while (done_cnt == d0 && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic wait_tx(input int cnt, input int budget);
    int c;
    c = 0;
    while (tx_q.size() < cnt && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  logic [7:0] exp_tx [8] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h11, 8'h22, 8'h33, 8'h44};

  initial begin : main
    int d0, cyc;
    rstn = 1'b0; rxd = 1'b1; mode = LOAD;
    io.start = 1'b0; io.req_in = 1'b0; io.req_out = 1'b0; io.req_bytes = '0; io.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 1);
    check("rst_busy", 32'(io.busy), 0);
    check("rst_done", 32'(io.done), 0);
    check("rst_rdata", io.rdata, 0);
    check("rst_aa_sent", 32'(aa_sent), 0);
    check("rst_rx_overflow", 32'(rx_overflow), 0);
    rstn = 1'b1;

    // 1: boot byte in LOAD mode, sent exactly once; AA on RX is flagged but not buffered
    cyc = 0;
    while (!aa_sent && cyc < 400) begin @(negedge clk); cyc++; end
    check("aa_sent", 32'(aa_sent), 1);
    send_rx(8'hAA);
    check("aa_received_cnt", aa_rx_cnt, 1);
    repeat (200) @(negedge clk);
    check("boot_frames", tx_q.size(), 1);
    check("boot_byte", q_at(0), 32'hAA);

    // 2: four-byte IN, little-endian
    mode = EXEC;
    send_rx(8'h78); send_rx(8'h56); send_rx(8'h34); send_rx(8'h12);
    d0 = done_cnt;
    issue(1'b1, 1'b0, 2'd3, 32'h0);
    wait_done(d0, 20, cyc);
    check("in4_done", done_cnt - d0, 1);
    check("in4_latency", cyc, 4);
    check("in4_rdata", io.rdata, 32'h1234_5678);
    check("in4_busy_fall", 32'(io.busy), 0);
    @(negedge clk); #1;
    check("in4_done_pulse", 32'(io.done), 0);

    // 3: IN stalls on empty RX, completes when a byte arrives
    d0 = done_cnt;
    issue(1'b1, 1'b0, 2'd0, 32'h0);
    repeat (20) @(negedge clk);
    check("in1_stall_busy", 32'(io.busy), 1);
    check("in1_stall_nodone", done_cnt - d0, 0);
    check("rdata_held", io.rdata, 32'h1234_5678);
    send_rx(8'h41);
    wait_done(d0, 20, cyc);
    check("in1_done", done_cnt - d0, 1);
    check("in1_rdata", io.rdata, 32'h0000_0041);
    check("in1_busy_fall", 32'(io.busy), 0);

    // 4: OUT ordering, second OUT stalls on full TX FIFO
    tx_q.delete();
    d0 = done_cnt;
    issue(1'b0, 1'b1, 2'd3, 32'hA1B2_C3D4);
    wait_done(d0, 20, cyc);
    check("out1_done", done_cnt - d0, 1);
    check("out1_latency", cyc, 4);
    d0 = done_cnt;
    issue(1'b0, 1'b1, 2'd3, 32'h4433_2211);
    repeat (30) @(negedge clk);
    check("out2_stall_busy", 32'(io.busy), 1);
    wait_done(d0, 1000, cyc);
    check("out2_done", done_cnt - d0, 1);
    wait_tx(8, 1200);
    check("out_frame_count", tx_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("out_byte%0d", i), q_at(i), {24'h0, exp_tx[i]});

    // 5: overflow of the depth-4 RX FIFO drops the fifth byte
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    check("ovf_before", 32'(rx_overflow), 0);
    send_rx(8'h05);
    check("ovf_after", 32'(rx_overflow), 1);
    d0 = done_cnt;
    issue(1'b1, 1'b0, 2'd3, 32'h0);
    wait_done(d0, 20, cyc);
    check("ovf_in_rdata", io.rdata, 32'h0403_0201);
    send_rx(8'h99);
    d0 = done_cnt;
    issue(1'b1, 1'b0, 2'd0, 32'h0);
    wait_done(d0, 20, cyc);
    check("ovf_dropped_byte", io.rdata, 32'h0000_0099);
    check("ovf_sticky", 32'(rx_overflow), 1);

    // 6: reset in the middle of a stalled OUT
    d0 = done_cnt;
    issue(1'b0, 1'b1, 2'd3, 32'h0D0C_0B0A);
    wait_done(d0, 20, cyc);
    issue(1'b0, 1'b1, 2'd3, 32'h1413_1211);
    repeat (30) @(negedge clk);
    check("rst2_pre_busy", 32'(io.busy), 1);
    rstn = 1'b0;
    #1;
    check("rst2_txd", 32'(txd), 1);
    check("rst2_busy", 32'(io.busy), 0);
    check("rst2_aa_sent", 32'(aa_sent), 0);
    check("rst2_rx_overflow", 32'(rx_overflow), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (150) @(negedge clk);
    tx_q.delete();
    repeat (100) @(negedge clk);
    check("rst2_tx_empty", tx_q.size(), 0);
    d0 = done_cnt;
    issue(1'b0, 1'b1, 2'd0, 32'h0000_005A);
    wait_done(d0, 20, cyc);
    check("post_rst_out_latency", cyc, 1);
    wait_tx(1, 300);
    check("post_rst_frames", tx_q.size(), 1);
    check("post_rst_byte", q_at(0), 32'h5A);
    check("done_single_cycle", 32'(done_wide), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
